// File: rtl/drawer_seq_ctrl.sv
// Drawer phase sequencer: LOAD pixel pairs -> settle -> COMPARE sweep -> settle -> DRAW frames; all outputs registered (1-cycle latency).
// Backpressure: pix_ready_o only in LOAD until the last beat. Optional DRAWER_SEQ_ABORT_EN adds abort_i (returns to IDLE).
module drawer_seq_ctrl #(
    parameter int NUM_PIXELS = 307200,
    parameter int ADDR_W     = 19,
    parameter int CMP_PITCH  = 4,
    parameter int SETTLE     = 5,
    parameter int FRAMES     = 1
) (
    input  logic              clk50_i,
    input  logic              reset_i,
    input  logic              start_i,
`ifdef DRAWER_SEQ_ABORT_EN
    input  logic              abort_i,
`endif
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    input  logic [23:0]       pix_d1_i,
    input  logic [23:0]       pix_d2_i,
    input  logic              frame_end_i,
    output logic [ADDR_W-1:0] address_o,
    output logic              wren1_o,
    output logic              wren2_o,
    output logic              wren3_o,
    output logic [23:0]       data1_o,
    output logic [23:0]       data2_o,
    output logic              enable_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int PITCH_W = $clog2(CMP_PITCH);
    localparam int SET_W   = $clog2(SETTLE + 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [PITCH_W-1:0] PITCH_LAST = PITCH_W'(CMP_PITCH - 1);
    localparam logic [SET_W-1:0]   SET_LAST   = SET_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAP1, S_COMPARE, S_GAP2, S_DRAW, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [ADDR_W-1:0]   beat_q, beat_d;
    logic [PITCH_W-1:0]  pitch_q, pitch_d;
    logic [SET_W-1:0]    gap_q, gap_d;
    logic [31:0]         frm_q, frm_d;
    logic [23:0]         data1_q, data1_d, data2_q, data2_d;
    logic                wren12_q, wren12_d;
    logic                wren3_q, wren3_d;
    logic                enable_q, enable_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                beat;

    assign beat = pix_valid_i & ready_q;

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        beat_d    = beat_q;
        pitch_d   = pitch_q;
        gap_d     = gap_q;
        frm_d     = frm_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        wren12_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_LOAD;
                    address_d = '0;
                    beat_d    = '0;
                    pitch_d   = '0;
                    gap_d     = '0;
                    frm_d     = '0;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    address_d = beat_q;
                    data1_d   = pix_d1_i;
                    data2_d   = pix_d2_i;
                    wren12_d  = 1'b1;
                    if (beat_q == LAST_ADDR) begin
                        state_d = S_GAP1;
                        gap_d   = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            // First GAP1 cycle still shows the final write, so the count starts at 0.
            S_GAP1: begin
                if (gap_q == SET_LAST) begin
                    state_d   = S_COMPARE;
                    address_d = '0;
                    pitch_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_COMPARE: begin
                if (pitch_q == PITCH_LAST) begin
                    pitch_d = '0;
                    if (address_q == LAST_ADDR) begin
                        state_d   = S_GAP2;
                        address_d = '0;
                        gap_d     = SET_W'(1);
                    end else begin
                        address_d = address_q + 1'b1;
                    end
                end else begin
                    pitch_d = pitch_q + 1'b1;
                end
            end
            S_GAP2: begin
                if (gap_q == SET_LAST) begin
                    state_d   = S_DRAW;
                    address_d = '0;
                    frm_d     = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DRAW: begin
                if (frame_end_i) begin
                    if (FRAMES != 0 && (frm_q + 32'd1) == FRAMES) begin
                        state_d = S_DONE;
                    end else begin
                        frm_d = frm_q + 32'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DRAWER_SEQ_ABORT_EN
        // Abort outranks everything decided above, including a beat this cycle.
        if (abort_i && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            address_d = '0;
            beat_d    = '0;
            pitch_d   = '0;
            gap_d     = '0;
            frm_d     = '0;
            data1_d   = '0;
            data2_d   = '0;
            wren12_d  = 1'b0;
        end
`endif

        ready_d  = (state_d == S_LOAD);
        wren3_d  = (state_d == S_COMPARE);
        enable_d = (state_d == S_DRAW);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk50_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            address_q <= '0;
            beat_q    <= '0;
            pitch_q   <= '0;
            gap_q     <= '0;
            frm_q     <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            wren12_q  <= 1'b0;
            wren3_q   <= 1'b0;
            enable_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            beat_q    <= beat_d;
            pitch_q   <= pitch_d;
            gap_q     <= gap_d;
            frm_q     <= frm_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            wren12_q  <= wren12_d;
            wren3_q   <= wren3_d;
            enable_q  <= enable_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pix_ready_o = ready_q;
    assign address_o   = address_q;
    assign wren1_o     = wren12_q;
    assign wren2_o     = wren12_q;
    assign wren3_o     = wren3_q;
    assign data1_o     = data1_q;
    assign data2_o     = data2_q;
    assign enable_o    = enable_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_drawer_seq_ctrl.sv
// Bench for drawer_seq_ctrl with NUM_PIXELS=8, CMP_PITCH=4, SETTLE=5, FRAMES=2.
module tb_drawer_seq_ctrl;
    localparam int N  = 8;
    localparam int P  = 4;
    localparam int S  = 5;
    localparam int F  = 2;
    localparam int AW = 19;

    logic          clk50 = 1'b0;
    logic          reset, start, pix_valid, frame_end;
    logic [23:0]   pix_d1, pix_d2;
`ifdef DRAWER_SEQ_ABORT_EN
    logic          abort;
`endif
    logic          pix_ready, wren1, wren2, wren3, enable, busy, done;
    logic [AW-1:0] address;
    logic [23:0]   data1, data2;

    int tests_run = 0;
    int tests_failed = 0;

    drawer_seq_ctrl #(.NUM_PIXELS(N), .ADDR_W(AW), .CMP_PITCH(P), .SETTLE(S), .FRAMES(F)) dut (
        .clk50_i(clk50), .reset_i(reset), .start_i(start),
`ifdef DRAWER_SEQ_ABORT_EN
        .abort_i(abort),
`endif
        .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_d1_i(pix_d1), .pix_d2_i(pix_d2),
        .frame_end_i(frame_end), .address_o(address), .wren1_o(wren1), .wren2_o(wren2),
        .wren3_o(wren3), .data1_o(data1), .data2_o(data2), .enable_o(enable),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk50 = ~clk50;

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests_run++;
        if ({address, data1, data2, wren1, wren2, wren3, enable, busy, done, pix_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got addr=%0d d1=%h d2=%h w=%b%b%b en=%b busy=%b done=%b rdy=%b, want all zero",
                     address, data1, data2, wren1, wren2, wren3, enable, busy, done, pix_ready);
        end
        reset = 1'b0;
        step();
        tests_run++;
        if ({busy, pix_ready, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_hold: got busy/rdy/done=%b, want 000", {busy, pix_ready, done});
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if ({pix_ready, busy, done, wren1, wren2, wren3, enable} !== 7'b1100000 || address !== '0) begin
            tests_failed++;
            $display("FAIL start_to_load: got rdy/busy/done/w1/w2/w3/en=%b addr=%0d, want 1100000 addr=0",
                     {pix_ready, busy, done, wren1, wren2, wren3, enable}, address);
        end
    endtask

    // mode 0: valid held high, data = beat index; mode 1: valid toggles; mode 2: random valid/start/frame_end
    task automatic test_load(input int mode);
        int beats = 0;
        logic [AW-1:0] last_a = '0;
        logic [23:0] ld1 = '0, ld2 = '0;
        logic v;
        logic [23:0] d1, d2;
        for (int cyc = 0; cyc < 400 && beats < N; cyc++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d1 = (mode == 0) ? 24'(beats) : 24'($urandom);
            d2 = (mode == 0) ? ~24'(beats) : 24'($urandom);
            pix_valid = v;
            pix_d1 = d1;
            pix_d2 = d2;
            if (mode == 2) begin
                start = 1'($urandom_range(0, 1));
                frame_end = 1'($urandom_range(0, 1));
            end
            tests_run++;
            if (pix_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL load_ready beat=%0d: got %b want 1", beats, pix_ready);
            end
            step();
            tests_run++;
            if (v) begin
                if ({wren1, wren2, wren3, enable} !== 4'b1100 || address !== AW'(beats) ||
                    data1 !== d1 || data2 !== d2) begin
                    tests_failed++;
                    $display("FAIL load_write beat=%0d: got w=%b addr=%0d d1=%h d2=%h want w=1100 addr=%0d d1=%h d2=%h",
                             beats, {wren1, wren2, wren3, enable}, address, data1, data2, beats, d1, d2);
                end
                last_a = AW'(beats);
                ld1 = d1;
                ld2 = d2;
                beats++;
            end else begin
                if ({wren1, wren2, wren3, enable} !== 4'b0000 ||
                    (beats > 0 && (address !== last_a || data1 !== ld1 || data2 !== ld2))) begin
                    tests_failed++;
                    $display("FAIL load_idle beat=%0d: got w=%b addr=%0d d1=%h want w=0000 addr=%0d d1=%h",
                             beats, {wren1, wren2, wren3, enable}, address, data1, last_a, ld1);
                end
            end
        end
        pix_valid = 1'b0;
        start = 1'b0;
        frame_end = 1'b0;
        tests_run++;
        if (beats != N || pix_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_end: got beats=%0d rdy=%b, want beats=%0d rdy=0", beats, pix_ready, N);
        end
    endtask

    task automatic test_compare_timing();
        int total = 2 * S + N * P;
        logic [4:0] exp_v;
        for (int t = 0; t <= total; t++) begin
            step();
            // expected {wren1,wren2,wren3,enable,busy}
            if (t < S)               exp_v = 5'b00001;
            else if (t < S + N * P)  exp_v = 5'b00101;
            else if (t < total)      exp_v = 5'b00001;
            else                     exp_v = 5'b00011;
            tests_run++;
            if ({wren1, wren2, wren3, enable, busy} !== exp_v) begin
                tests_failed++;
                $display("FAIL phase_strobes t=%0d: got %b want %b", t, {wren1, wren2, wren3, enable, busy}, exp_v);
            end
            if (t >= S) begin
                tests_run++;
                if (t < S + N * P) begin
                    if (address !== AW'((t - S) / P)) begin
                        tests_failed++;
                        $display("FAIL compare_addr t=%0d: got %0d want %0d", t, address, (t - S) / P);
                    end
                end else if (address !== '0) begin
                    tests_failed++;
                    $display("FAIL gap2_draw_addr t=%0d: got %0d want 0", t, address);
                end
            end
        end
    endtask

    task automatic test_draw();
        int frames = 0;
        int w0 = $urandom_range(1, 20);
        for (int i = 0; i < w0; i++) begin
            step();
            tests_run++;
            if ({enable, done} !== 2'b10) begin
                tests_failed++;
                $display("FAIL draw_wait i=%0d: got en/done=%b want 10", i, {enable, done});
            end
        end
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        frames++;
        repeat (99) step();
        tests_run++;
        if (enable !== (frames < F) || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL draw_after_frame1: got en=%b done=%b want en=%b done=0", enable, done, frames < F);
        end
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        frames++;
        tests_run++;
        if ({enable, done, busy} !== {frames < F, frames >= F, frames < F}) begin
            tests_failed++;
            $display("FAIL draw_after_frame2: got en/done/busy=%b want %b",
                     {enable, done, busy}, {frames < F, frames >= F, frames < F});
        end
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        tests_run++;
        if ({enable, done, busy, pix_ready} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL done_ignores_frame_end: got en/done/busy/rdy=%b want 0100", {enable, done, busy, pix_ready});
        end
    endtask

    task automatic test_reset_mid_compare();
        int k = S + 1 + $urandom_range(0, N * P - 2);
        repeat (k) step();
        tests_run++;
        if (wren3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL in_compare k=%0d: got wren3=%b want 1", k, wren3);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if ({address, wren1, wren3, enable, busy, done, pix_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_compare: got addr=%0d w1=%b w3=%b en=%b busy=%b done=%b rdy=%b, want all zero",
                     address, wren1, wren3, enable, busy, done, pix_ready);
        end
        step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_load();
        pix_valid = 1'b1;
        pix_d1 = 24'h123456;
        pix_d2 = 24'h654321;
        repeat (3) step();
        pix_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if ({address, data1, data2, busy, pix_ready, wren1} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_load: got addr=%0d d1=%h busy=%b rdy=%b w1=%b, want all zero",
                     address, data1, busy, pix_ready, wren1);
        end
    endtask

`ifdef DRAWER_SEQ_ABORT_EN
    task automatic test_abort();
        test_start();
        pix_valid = 1'b1;
        pix_d1 = 24'hABCDEF;
        pix_d2 = 24'h012345;
        abort = 1'b1;
        step();
        abort = 1'b0;
        pix_valid = 1'b0;
        tests_run++;
        if ({wren1, wren2, busy, pix_ready, done} !== 5'b00000 || address !== '0 || data1 !== '0) begin
            tests_failed++;
            $display("FAIL abort_beat: got w1/w2/busy/rdy/done=%b addr=%0d d1=%h want 00000 addr=0 d1=0",
                     {wren1, wren2, busy, pix_ready, done}, address, data1);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        frame_end = 1'b0;
        pix_d1 = '0;
        pix_d2 = '0;
`ifdef DRAWER_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_start();
        test_load(0);
        test_compare_timing();
        test_draw();
        test_start();
        test_load(1);
        test_compare_timing();
        test_draw();
        test_start();
        test_load(2);
        test_reset_mid_compare();
        test_start();
        test_reset_mid_load();
        test_start();
        test_load(0);
        test_compare_timing();
`ifdef DRAWER_SEQ_ABORT_EN
        test_abort();
        test_start();
        test_load(0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
